// File: rtl/encode_packet_stream.sv
// encode_packet_stream: splits one DFX word into {payload, ttl, seq, src} flits streamed under valid/ready
module encode_packet_stream #(
  parameter int DATA_WIDTH        = 1024,
  parameter int ADDR_WIDTH        = 10,
  parameter int DATA_DFX_WIDTH    = DATA_WIDTH + ADDR_WIDTH,
  parameter int AURORA_DATA_WIDTH = 256,
  parameter int TTL_WIDTH         = 2,
  parameter int SEQ_WIDTH         = 3,
  parameter int SRC_WIDTH         = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_start_encode_pkt,
  input  logic [DATA_DFX_WIDTH-1:0]    i_data_dfx_send,
  input  logic [TTL_WIDTH-1:0]         i_ttl_init,
  input  logic [SRC_WIDTH-1:0]         i_src_router,
  output logic                         o_ready_encode_pkt,
  output logic                         o_encode_done,
  output logic                         o_encode_valid,
  input  logic                         i_encode_ready,
  output logic                         o_encode_last,
  output logic [AURORA_DATA_WIDTH-1:0] o_data_send
);
  localparam int HDR_WIDTH     = TTL_WIDTH + SEQ_WIDTH + SRC_WIDTH;
  localparam int PAYLOAD_WIDTH = AURORA_DATA_WIDTH - HDR_WIDTH;
  localparam int NUM_FLITS     = (DATA_DFX_WIDTH + PAYLOAD_WIDTH - 1) / PAYLOAD_WIDTH;
  localparam int PAD_WIDTH     = NUM_FLITS * PAYLOAD_WIDTH;
  if (NUM_FLITS > 2 ** SEQ_WIDTH || PAYLOAD_WIDTH <= 0) begin : g_param_check
    $error("encode_packet_stream: flit count does not fit the sequence field or payload width is not positive");
  end
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  state_t                 r_state;
  logic [PAD_WIDTH-1:0]   r_dfx;
  logic [TTL_WIDTH-1:0]   r_ttl;
  logic [SRC_WIDTH-1:0]   r_src;
  logic [SEQ_WIDTH-1:0]   r_k;
  logic [PAD_WIDTH-1:0]   w_in_pad;
  logic [SEQ_WIDTH-1:0]   w_k_nxt;
  logic                   w_accept;
  logic                   w_xfer;
  logic                   w_is_last;
  assign w_in_pad  = PAD_WIDTH'(i_data_dfx_send);
  assign w_k_nxt   = r_k + 1'b1;
  assign w_accept  = (r_state == IDLE) && i_start_encode_pkt && o_ready_encode_pkt;
  assign w_xfer    = o_encode_valid && i_encode_ready;
  assign w_is_last = r_k == SEQ_WIDTH'(NUM_FLITS - 1);
  function automatic logic [AURORA_DATA_WIDTH-1:0] flit(
    input logic [PAD_WIDTH-1:0] d,
    input logic [TTL_WIDTH-1:0] t,
    input logic [SEQ_WIDTH-1:0] k,
    input logic [SRC_WIDTH-1:0] s
  );
    return {d[int'(k) * PAYLOAD_WIDTH +: PAYLOAD_WIDTH], t, k, s};
  endfunction
  // Packet FSM: capture on accept, advance one flit per handshake, pulse done, then re-arm ready
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state            <= IDLE;
      r_dfx              <= '0;
      r_ttl              <= '0;
      r_src              <= '0;
      r_k                <= '0;
      o_ready_encode_pkt <= 1'b0;
      o_encode_done      <= 1'b0;
      o_encode_valid     <= 1'b0;
      o_encode_last      <= 1'b0;
      o_data_send        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_dfx              <= w_in_pad;
            r_ttl              <= i_ttl_init;
            r_src              <= i_src_router;
            r_k                <= '0;
            o_data_send        <= flit(w_in_pad, i_ttl_init, '0, i_src_router);
            o_encode_valid     <= 1'b1;
            o_encode_last      <= NUM_FLITS == 1;
            o_ready_encode_pkt <= 1'b0;
            r_state            <= SEND;
          end else begin
            o_ready_encode_pkt <= 1'b1;
          end
        end
        SEND: begin
          if (w_xfer && w_is_last) begin
            o_encode_valid <= 1'b0;
            o_encode_last  <= 1'b0;
            o_data_send    <= '0;
            o_encode_done  <= 1'b1;
            r_state        <= DONE;
          end else if (w_xfer) begin
            r_k           <= w_k_nxt;
            o_data_send   <= flit(r_dfx, r_ttl, w_k_nxt, r_src);
            o_encode_last <= w_k_nxt == SEQ_WIDTH'(NUM_FLITS - 1);
          end
        end
        DONE: begin
          o_encode_done      <= 1'b0;
          o_ready_encode_pkt <= 1'b1;
          r_k                <= '0;
          r_state            <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_encode_packet_stream.sv
// tb_encode_packet_stream: scoreboard plus directed literals for default and 128-bit/9-flit variants
module tb_encode_packet_stream;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_a = 1'b0, start_b = 1'b0, rdy_a = 1'b0, rdy_b = 1'b0;
  logic [1033:0] dfx = '0;
  logic [1:0]   ttl = '0, src = '0;
  logic         ready_a, done_a, valid_a, last_a;
  logic [255:0] data_a;
  logic         ready_b, done_b, valid_b, last_b;
  logic [127:0] data_b;
  int           n_chk = 0, n_pass = 0;
  logic [255:0] mfl [2][16];
  int           mhead [2];
  int           mcnt [2];
  bit           mready [2];
  bit           mdone [2];

  always #5 clk = ~clk;

  encode_packet_stream u_a (
    .clk(clk), .rst(rst),
    .i_start_encode_pkt(start_a), .i_data_dfx_send(dfx), .i_ttl_init(ttl), .i_src_router(src),
    .o_ready_encode_pkt(ready_a), .o_encode_done(done_a), .o_encode_valid(valid_a),
    .i_encode_ready(rdy_a), .o_encode_last(last_a), .o_data_send(data_a)
  );

  encode_packet_stream #(.AURORA_DATA_WIDTH(128), .SEQ_WIDTH(4)) u_b (
    .clk(clk), .rst(rst),
    .i_start_encode_pkt(start_b), .i_data_dfx_send(dfx), .i_ttl_init(ttl), .i_src_router(src),
    .o_ready_encode_pkt(ready_b), .o_encode_done(done_b), .o_encode_valid(valid_b),
    .i_encode_ready(rdy_b), .o_encode_last(last_b), .o_data_send(data_b)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Flit k straight from the packet format: slice of the word, zero beyond its end, header below
  function automatic logic [255:0] model_flit(input logic [1033:0] d, input int k, input int pw,
                                              input int sw, input logic [1:0] t, input logic [1:0] s);
    logic [1279:0] p;
    logic [255:0]  h;
    p = {246'b0, d} >> (k * pw);
    p = p & ((1280'b1 << pw) - 1280'b1);
    h = (256'(t) << (sw + 2)) | (256'(k) << 2) | 256'(s);
    return 256'(p << (sw + 4)) | h;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      int   pw, sw, nf;
      logic st, rd;
      pw = u ? 120 : 249;
      sw = u ? 4 : 3;
      nf = (1034 + pw - 1) / pw;
      st = u ? start_b : start_a;
      rd = u ? rdy_b : rdy_a;
      check($sformatf("dut%0d valid", u), 256'(u ? valid_b : valid_a), 256'(mcnt[u] > 0));
      check($sformatf("dut%0d data", u), u ? 256'(data_b) : data_a, mcnt[u] > 0 ? mfl[u][mhead[u]] : '0);
      check($sformatf("dut%0d last", u), 256'(u ? last_b : last_a), 256'(mcnt[u] == 1));
      check($sformatf("dut%0d done", u), 256'(u ? done_b : done_a), 256'(mdone[u]));
      check($sformatf("dut%0d ready", u), 256'(u ? ready_b : ready_a), 256'(mready[u]));
      if (rst) begin
        mcnt[u] = 0;
        mready[u] = 1'b0;
        mdone[u] = 1'b0;
      end else if (mcnt[u] > 0) begin
        mready[u] = 1'b0;
        if (rd) begin
          mhead[u]++;
          mcnt[u]--;
          mdone[u] = mcnt[u] == 0;
        end
      end else if (mdone[u]) begin
        mdone[u] = 1'b0;
        mready[u] = 1'b1;
      end else if (st && mready[u]) begin
        for (int k = 0; k < nf; k++) mfl[u][k] = model_flit(dfx, k, pw, sw, ttl, src);
        mhead[u] = 0;
        mcnt[u] = nf;
        mready[u] = 1'b0;
      end else begin
        mready[u] = 1'b1;
      end
    end
  end

  initial begin
    logic [1039:0] t;
    logic [1033:0] p1, p2;
    for (int i = 0; i < 130; i++) t[8*i +: 8] = 8'(i);
    p1 = t[1033:0];
    p2 = ~p1;
    tick(3);
    check("reset ctl", 256'({ready_a, done_a, valid_a, last_a}), 256'(0));
    check("reset data", data_a, '0);
    rst = 1'b0;
    tick();
    check("ready after release", 256'(ready_a), 256'(1));
    dfx = p1; ttl = 2'd2; src = 2'd1; rdy_a = 1'b1; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("flit0 hdr", 256'(data_a[6:0]), 256'(7'h41));
    check("flit0 payload", 256'(data_a[30:7]), 256'(24'h020100));
    tick(4);
    check("flit4 hdr", 256'(data_a[6:0]), 256'(7'h51));
    check("flit4 payload", 256'(data_a[44:7]), 256'({2'b01, 8'h80, 8'h7f, 8'h7e, 8'h7d, 4'h7}));
    check("flit4 zero pad", 256'(data_a[255:45]), '0);
    check("flit4 last", 256'(last_a), 256'(1));
    tick();
    check("done pulse", 256'({done_a, valid_a}), 256'(2'b10));
    tick();
    check("ready after done", 256'({done_a, ready_a}), 256'(2'b01));
    dfx = p2; start_a = 1'b1;
    tick();
    start_a = 1'b0; dfx = p1; ttl = 2'd3; src = 2'd2;
    tick(2);
    check("stall flit2 seq", 256'(data_a[4:2]), 256'(3'd2));
    rdy_a = 1'b0; start_a = 1'b1;
    for (int i = 0; i < 1034; i += 32) dfx[i +: 10] = 10'($urandom);
    tick(3);
    check("held flit2 seq", 256'(data_a[4:2]), 256'(3'd2));
    start_a = 1'b0; rdy_a = 1'b1;
    tick(3);
    check("stall done timing", 256'(done_a), 256'(1));
    tick();
    dfx = p1; ttl = 2'd1; src = 2'd3; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick(3);
    check("flit3 before reset", 256'(data_a[4:2]), 256'(3'd3));
    rst = 1'b1;
    tick();
    check("mid reset ctl", 256'({ready_a, done_a, valid_a, last_a}), 256'(0));
    check("mid reset data", data_a, '0);
    rst = 1'b0;
    tick();
    check("ready after mid reset", 256'({ready_a, valid_a}), 256'(2'b10));
    ttl = 2'd0; src = 2'd2; start_a = 1'b1;
    tick();
    check("b2b first", 256'({valid_a, data_a[4:2]}), 256'(4'b1000));
    tick(6);
    check("b2b gap", 256'({valid_a, ready_a}), 256'(2'b01));
    tick();
    check("b2b second", 256'({valid_a, data_a[4:2]}), 256'(4'b1000));
    tick(13);
    start_a = 1'b0;
    tick(10);
    dfx = p1; ttl = 2'd2; src = 2'd1; rdy_b = 1'b1; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("var flit0 hdr", 256'(data_b[7:0]), 256'(8'b10_0000_01));
    tick(8);
    check("var flit8", 256'(data_b), 256'({46'b0, 2'b01, 8'h80, 8'h7f, 8'h7e, 8'h7d, 8'h7c,
                                            8'h7b, 8'h7a, 8'h79, 8'h78, 8'b10_1000_01}));
    check("var flit8 last", 256'(last_b), 256'(1));
    tick(4);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
